// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode encodings and the illegal-opcode test.
package alu_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int RES_WIDTH  = 5;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOTA = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_ADC  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SBB  = 4'b0111;
  localparam logic [3:0] OP_INCA = 4'b1000;
  localparam logic [3:0] OP_INCB = 4'b1001;
  localparam logic [3:0] OP_DECB = 4'b1010;
  localparam logic [3:0] OP_DECA = 4'b1011;

  // Encodings 4'b1100..4'b1111 are undefined; the ALU returns zero for them.
  function automatic logic is_illegal(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic            found;
  logic [ID_W-1:0] idx;

  // Scan requesters starting at ptr and take the first one that is asking.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one registered ALU between NUM_REQ requesters; round-robin issue,
// tag pipeline matched to the ALU latency, tagged responses.
module alu_rr_scheduler #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter  int OP_WIDTH   = 4,
  parameter  int ALU_LAT    = 2,
  parameter  int CNT_WIDTH  = 8,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
  input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op,
  input  logic [NUM_REQ-1:0]             req_ci,
  input  logic [NUM_REQ-1:0]             req_bi,
  output logic [DATA_WIDTH-1:0]          alu_a,
  output logic [DATA_WIDTH-1:0]          alu_b,
  output logic [OP_WIDTH-1:0]            alu_opcode,
  output logic                           alu_ci,
  output logic                           alu_bi,
  input  logic [DATA_WIDTH:0]            alu_result,
  output logic                           rsp_valid,
  output logic [ID_W-1:0]                rsp_id,
  output logic [DATA_WIDTH:0]            rsp_data,
  output logic                           rsp_illegal,
  output logic                           busy,
  output logic [CNT_WIDTH-1:0]           issue_cnt
);

  import alu_pkg::*;

  logic [NUM_REQ-1:0]            arb_req;
  logic [NUM_REQ-1:0]            grant;
  logic [ID_W-1:0]               grant_id;
  logic [ID_W-1:0]               ptr;
  logic                          grant_any;

  logic [ALU_LAT-1:0]            tag_valid;
  logic [ALU_LAT-1:0]            tag_ill;
  logic [ALU_LAT-1:0][ID_W-1:0]  tag_id;

  logic [ID_W-1:0]               rsp_id_q;
  logic [DATA_WIDTH:0]           rsp_data_q;

  // Grants are suppressed while disabled and while reset is held, so nothing
  // can be handshaken during reset.
  assign arb_req   = req_valid & {NUM_REQ{en & rst_n}};
  assign req_ready = grant;
  assign grant_any = |grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (arb_req),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Steer the granted requester's operands onto the ALU; idle drives zeros.
  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = '0;
    alu_ci     = 1'b0;
    alu_bi     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        alu_a      = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        alu_b      = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        alu_opcode = req_op[i*OP_WIDTH +: OP_WIDTH];
        alu_ci     = req_ci[i];
        alu_bi     = req_bi[i];
      end
    end
  end

  // Advance the round-robin pointer past the winner and count issued ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      issue_cnt <= '0;
    end else if (grant_any) begin
      ptr       <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      issue_cnt <= issue_cnt + CNT_WIDTH'(1);
    end
  end

  // Tag pipeline shadows the ALU's register stages so each result is matched
  // to its requester; it never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      tag_ill   <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid[0] <= grant_any;
      tag_ill[0]   <= grant_any & is_illegal(alu_opcode);
      tag_id[0]    <= grant_id;
      for (int i = 1; i < ALU_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_ill[i]   <= tag_ill[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  // Remember the last delivered response so id/data hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else if (rsp_valid) begin
      rsp_id_q   <= tag_id[ALU_LAT-1];
      rsp_data_q <= alu_result;
    end
  end

  assign rsp_valid   = tag_valid[ALU_LAT-1];
  assign rsp_illegal = rsp_valid & tag_ill[ALU_LAT-1];
  assign rsp_id      = rsp_valid ? tag_id[ALU_LAT-1] : rsp_id_q;
  assign rsp_data    = rsp_valid ? alu_result : rsp_data_q;
  assign busy        = |tag_valid;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a two-register behavioural ALU attached.
module tb_alu_rr_scheduler;

  import alu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DW      = 4;
  localparam int OW      = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   en;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*DW-1:0]  req_a;
  logic [NUM_REQ*DW-1:0]  req_b;
  logic [NUM_REQ*OW-1:0]  req_op;
  logic [NUM_REQ-1:0]     req_ci;
  logic [NUM_REQ-1:0]     req_bi;
  logic [DW-1:0]          alu_a;
  logic [DW-1:0]          alu_b;
  logic [OW-1:0]          alu_opcode;
  logic                   alu_ci;
  logic                   alu_bi;
  logic [DW:0]            alu_result;
  logic                   rsp_valid;
  logic [1:0]             rsp_id;
  logic [DW:0]            rsp_data;
  logic                   rsp_illegal;
  logic                   busy;
  logic [7:0]             issue_cnt;

  int errors = 0;
  int checks = 0;

  alu_rr_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .OP_WIDTH(OW), .ALU_LAT(2), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_ci(req_ci), .req_bi(req_bi),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_ci(alu_ci), .alu_bi(alu_bi),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_illegal(rsp_illegal),
    .busy(busy), .issue_cnt(issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the shared ALU: input register then output register.
  function automatic logic [RES_WIDTH-1:0] aluModel(input logic [3:0] a, input logic [3:0] b,
                                                    input logic [3:0] op, input logic ci, input logic bi);
    logic [RES_WIDTH-1:0] r;
    case (op)
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_NOTA: r = {1'b0, ~a};
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_ADC:  r = {1'b0, a} + {1'b0, b} + {4'b0, ci};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_SBB:  r = {1'b0, a} - {1'b0, b} - {4'b0, bi};
      OP_INCA: r = {1'b0, a} + 5'd1;
      OP_INCB: r = {1'b0, b} + 5'd1;
      OP_DECB: r = {1'b0, b} - 5'd1;
      OP_DECA: r = {1'b0, a} - 5'd1;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [3:0] a_q, b_q, op_q;
  logic       ci_q, bi_q;
  logic [4:0] res_q;

  // ALU register stages; deliberately not reset so stale results remain visible.
  always @(posedge clk) begin
    a_q   <= alu_a;
    b_q   <= alu_b;
    op_q  <= alu_opcode;
    ci_q  <= alu_ci;
    bi_q  <= alu_bi;
    res_q <= aluModel(a_q, b_q, op_q, ci_q, bi_q);
  end
  assign alu_result = res_q;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] op, input logic ci, input logic bi);
    req_a[id*DW +: DW]  = a;
    req_b[id*DW +: DW]  = b;
    req_op[id*OW +: OW] = op;
    req_ci[id]          = ci;
    req_bi[id]          = bi;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1;
    req_valid = 4'hF; req_a = '0; req_b = '0; req_op = '0; req_ci = '0; req_bi = '0;

    // Reset state, with requests pending
    #2;
    checkOutput("rst_ready",  32'(req_ready),  32'h0);
    checkOutput("rst_valid",  32'(rsp_valid),  32'h0);
    checkOutput("rst_busy",   32'(busy),       32'h0);
    checkOutput("rst_cnt",    32'(issue_cnt),  32'h0);
    checkOutput("rst_data",   32'(rsp_data),   32'h0);
    checkOutput("rst_alu_a",  32'(alu_a),      32'h0);
    req_valid = '0;
    #10 rst_n = 1'b1;

    // Single request from requester 1: 7 + 9 = 0x10
    tick();
    applyStimulus(1, 4'h7, 4'h9, OP_ADD, 1'b0, 1'b0);
    req_valid = 4'b0010;
    #1;
    checkOutput("single_ready", 32'(req_ready),  32'b0010);
    checkOutput("single_alu_a", 32'(alu_a),      32'h7);
    checkOutput("single_alu_b", 32'(alu_b),      32'h9);
    checkOutput("single_op",    32'(alu_opcode), 32'(OP_ADD));
    tick();
    req_valid = '0;
    #1;
    checkOutput("single_c1_valid", 32'(rsp_valid), 32'h0);
    checkOutput("single_c1_busy",  32'(busy),      32'h1);
    tick();
    checkOutput("single_c2_valid", 32'(rsp_valid),   32'h1);
    checkOutput("single_c2_id",    32'(rsp_id),      32'h1);
    checkOutput("single_c2_data",  32'(rsp_data),    32'b10000);
    checkOutput("single_c2_ill",   32'(rsp_illegal), 32'h0);
    checkOutput("single_c2_cnt",   32'(issue_cnt),   32'h1);
    tick();
    checkOutput("single_c3_valid", 32'(rsp_valid), 32'h0);
    checkOutput("single_c3_busy",  32'(busy),      32'h0);

    // All four requesters pending from pointer 0: grants 0,1,2,3,0; each adds a=id, b=1
    doReset();
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 4'(i), 4'h1, OP_ADD, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 0) req_valid = 4'hF;
      if (c == 5) req_valid = 4'h0;
      #1;
      checkOutput($sformatf("rr_ready_c%0d", c), 32'(req_ready),
                  (c < 5) ? (32'h1 << (c % 4)) : 32'h0);
      if (c >= 2) begin
        checkOutput($sformatf("rr_valid_c%0d", c), 32'(rsp_valid), 32'h1);
        checkOutput($sformatf("rr_id_c%0d", c),    32'(rsp_id),    32'((c - 2) % 4));
        checkOutput($sformatf("rr_data_c%0d", c),  32'(rsp_data),  32'((c - 2) % 4 + 1));
      end else begin
        checkOutput($sformatf("rr_valid_c%0d", c), 32'(rsp_valid), 32'h0);
      end
    end

    // Back-to-back from requester 0 (pointer is 1, so the search wraps)
    tick();
    applyStimulus(0, 4'hF, 4'h0, OP_INCA, 1'b0, 1'b0);
    req_valid = 4'b0001;
    #1 checkOutput("b2b_ready0", 32'(req_ready), 32'b0001);
    tick();
    applyStimulus(0, 4'h3, 4'h3, OP_SBB, 1'b0, 1'b1);
    #1 checkOutput("b2b_ready1", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    #1;
    checkOutput("b2b_valid0", 32'(rsp_valid), 32'h1);
    checkOutput("b2b_data0",  32'(rsp_data),  32'b10000);
    checkOutput("b2b_id0",    32'(rsp_id),    32'h0);
    tick();
    checkOutput("b2b_valid1", 32'(rsp_valid), 32'h1);
    checkOutput("b2b_data1",  32'(rsp_data),  32'b11111);
    tick();
    checkOutput("b2b_valid2", 32'(rsp_valid), 32'h0);

    // Illegal opcode from requester 2
    applyStimulus(2, 4'h5, 4'h5, 4'b1101, 1'b0, 1'b0);
    req_valid = 4'b0100;
    #1;
    checkOutput("ill_ready", 32'(req_ready), 32'b0100);
    checkOutput("ill_cnt0",  32'(issue_cnt), 32'd7);
    tick();
    req_valid = '0;
    #1;
    checkOutput("ill_cnt1",   32'(issue_cnt), 32'd8);
    checkOutput("ill_valid1", 32'(rsp_valid), 32'h0);
    tick();
    checkOutput("ill_valid2", 32'(rsp_valid),   32'h1);
    checkOutput("ill_flag",   32'(rsp_illegal), 32'h1);
    checkOutput("ill_data",   32'(rsp_data),    32'h0);
    checkOutput("ill_id",     32'(rsp_id),      32'h2);

    // Two ops in flight, then asynchronous reset pulse between edges
    tick();
    applyStimulus(0, 4'h1, 4'h2, OP_ADD, 1'b0, 1'b0);
    applyStimulus(1, 4'h4, 4'h4, OP_ADD, 1'b0, 1'b0);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    #1 checkOutput("arst_ready1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    #1;
    checkOutput("arst_pre_valid", 32'(rsp_valid), 32'h1);
    checkOutput("arst_pre_data",  32'(rsp_data),  32'h3);
    checkOutput("arst_pre_busy",  32'(busy),      32'h1);
    #2 rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    checkOutput("arst_ready", 32'(req_ready),   32'h0);
    checkOutput("arst_valid", 32'(rsp_valid),   32'h0);
    checkOutput("arst_busy",  32'(busy),        32'h0);
    checkOutput("arst_cnt",   32'(issue_cnt),   32'h0);
    checkOutput("arst_data",  32'(rsp_data),    32'h0);
    checkOutput("arst_id",    32'(rsp_id),      32'h0);
    checkOutput("arst_ill",   32'(rsp_illegal), 32'h0);
    checkOutput("arst_alu_a", 32'(alu_a),       32'h0);
    checkOutput("arst_alu_op", 32'(alu_opcode), 32'h0);
    req_valid = '0;
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("arst_post_valid_c%0d", c), 32'(rsp_valid), 32'h0);
      checkOutput($sformatf("arst_post_busy_c%0d", c),  32'(busy),      32'h0);
    end

    // Disable with requests pending; in-flight op still completes
    applyStimulus(1, 4'h2, 4'h2, OP_ADD, 1'b0, 1'b0);
    req_valid = 4'b0010;
    #1 checkOutput("en_ready_g0", 32'(req_ready), 32'b0010);
    tick();
    en = 1'b0;
    req_valid = 4'b1011;
    #1;
    checkOutput("en_ready_g1", 32'(req_ready), 32'h0);
    checkOutput("en_alu_a_g1", 32'(alu_a),     32'h0);
    checkOutput("en_busy_g1",  32'(busy),      32'h1);
    tick();
    checkOutput("en_ready_g2", 32'(req_ready), 32'h0);
    checkOutput("en_valid_g2", 32'(rsp_valid), 32'h1);
    checkOutput("en_id_g2",    32'(rsp_id),    32'h1);
    checkOutput("en_data_g2",  32'(rsp_data),  32'h4);
    tick();
    checkOutput("en_ready_g3", 32'(req_ready), 32'h0);
    checkOutput("en_busy_g3",  32'(busy),      32'h0);
    checkOutput("en_cnt_g3",   32'(issue_cnt), 32'h1);

    // Re-enable: pointer is 2, requester 2 idle, so 3 then 0 then 1
    tick();
    en = 1'b1;
    #1 checkOutput("reen_ready_h0", 32'(req_ready), 32'b1000);
    tick();
    checkOutput("reen_ready_h1", 32'(req_ready), 32'b0001);
    tick();
    checkOutput("reen_ready_h2", 32'(req_ready), 32'b0010);
    tick();
    checkOutput("wrap_cnt4", 32'(issue_cnt), 32'd4);

    // Keep issuing every cycle until the counter wraps
    for (int k = 0; k < 251; k++) tick();
    checkOutput("wrap_cnt255", 32'(issue_cnt), 32'd255);
    tick();
    checkOutput("wrap_cnt0", 32'(issue_cnt), 32'd0);
    req_valid = '0;
    for (int c = 0; c < 3; c++) tick();
    checkOutput("final_busy", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
